// File: rtl/matmul_pkg.sv
// Shared types and helpers for the parametrised matrix multiplier.
package matmul_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        CALC,
        OUT
    } state_t;

    // Widest accumulator the output shaping function can handle.
    localparam int MAX_AW = 64;

    typedef struct packed {
        logic              ovf;
        logic [MAX_AW-1:0] data;
    } shaped_t;

    // Ceiling log2, usable in parameter and localparam expressions.
    function automatic int clog2_f(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // Reduce a sign/zero-extended accumulator to dw bits, either clamping or
    // keeping the low bits, and flag whether the value could not be represented.
    function automatic shaped_t shape_result(
        input logic [MAX_AW-1:0] acc,
        input int                dw,
        input bit                is_signed,
        input bit                sat
    );
        shaped_t           r;
        logic [MAX_AW-1:0] mask;
        logic [MAX_AW-1:0] kept;
        logic [MAX_AW-1:0] ext;
        logic [MAX_AW-1:0] hi;
        logic [MAX_AW-1:0] lo;
        logic              neg;
        mask   = (MAX_AW'(1) << dw) - MAX_AW'(1);
        kept   = acc & mask;
        hi     = mask >> 1;
        lo     = ~hi;
        neg    = |(kept & (MAX_AW'(1) << (dw - 1)));
        ext    = neg ? (kept | ~mask) : kept;
        r.ovf  = 1'b0;
        r.data = kept;
        if (is_signed) begin
            if (sat) begin
                if ($signed(acc) > $signed(hi)) begin
                    r.data = hi & mask;
                    r.ovf  = 1'b1;
                end else if ($signed(acc) < $signed(lo)) begin
                    r.data = lo & mask;
                    r.ovf  = 1'b1;
                end
            end else begin
                r.ovf = (ext != acc);
            end
        end else begin
            if (sat) begin
                if (acc > mask) begin
                    r.data = mask;
                    r.ovf  = 1'b1;
                end
            end else begin
                r.ovf = (kept != acc);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// Multiply-accumulate unit: registered accumulator, clear-on-first-product,
// and a saturate/truncate stage that shapes the running sum to DW bits.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int DW     = 8,
    parameter int SIGNED = 1,
    parameter int AW     = 2*DW + 4
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic          sat_en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] res,
    output logic          ovf
);

    logic [AW-1:0]     acc;
    logic [AW-1:0]     prod_ext;
    logic [AW-1:0]     sum;
    logic [MAX_AW-1:0] sum_wide;
    shaped_t           shaped;
    logic              unused_shaped_bits;

    // The product is formed at full 2*DW width and widened according to the
    // operand interpretation, so the accumulator never sees a wrapped product.
    generate
        if (SIGNED != 0) begin : g_signed
            logic signed [2*DW-1:0] a_ext;
            logic signed [2*DW-1:0] b_ext;
            logic signed [2*DW-1:0] prod;
            assign a_ext    = {{DW{a[DW-1]}}, a};
            assign b_ext    = {{DW{b[DW-1]}}, b};
            assign prod     = a_ext * b_ext;
            assign prod_ext = {{(AW-2*DW){prod[2*DW-1]}}, prod};
            assign sum_wide = {{(MAX_AW-AW){sum[AW-1]}}, sum};
        end else begin : g_unsigned
            logic [2*DW-1:0] a_ext;
            logic [2*DW-1:0] b_ext;
            logic [2*DW-1:0] prod;
            assign a_ext    = {{DW{1'b0}}, a};
            assign b_ext    = {{DW{1'b0}}, b};
            assign prod     = a_ext * b_ext;
            assign prod_ext = {{(AW-2*DW){1'b0}}, prod};
            assign sum_wide = {{(MAX_AW-AW){1'b0}}, sum};
        end
    endgenerate

    // Next accumulator value; shaping works on it directly so the final sum is
    // available in the same cycle as the last product.
    always_comb begin
        sum                = (clr ? '0 : acc) + prod_ext;
        shaped             = shape_result(sum_wide, DW, SIGNED != 0, sat_en);
        res                = shaped.data[DW-1:0];
        ovf                = shaped.ovf;
        unused_shaped_bits = ^shaped.data[MAX_AW-1:DW];
    end

    // Accumulator register, advanced only while the controller is calculating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/matmul_param.sv
// Parametrised NxN matrix multiplier: streams in A then B, computes C = A x B
// one MAC per cycle, then streams C out with per-element overflow flags.
module matmul_param
    import matmul_pkg::*;
#(
    parameter int N      = 3,
    parameter int DW     = 8,
    parameter int SIGNED = 1,
    parameter int AW     = 2*DW + clog2_f(N)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          st,
    input  logic          sat_en,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] data_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] dataout,
    output logic          out_ovf,
    output logic          busy,
    output logic          done
);

    localparam int NN = N * N;
    localparam int CW = clog2_f(NN);
    localparam int KW = clog2_f(N);
    localparam logic [CW-1:0] LAST_ELEM = CW'(NN - 1);
    localparam logic [KW-1:0] LAST_IDX  = KW'(N - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] next_cnt;
    logic [KW-1:0] i_idx;
    logic [KW-1:0] j_idx;
    logic [KW-1:0] k_idx;
    logic          sat_reg;

    logic [DW-1:0] a_mem [NN];
    logic [DW-1:0] b_mem [NN];
    logic [DW-1:0] r_mem [NN];
    logic          r_ovf [NN];

    logic [CW-1:0] a_addr;
    logic [CW-1:0] b_addr;
    logic [CW-1:0] r_addr;
    logic          beat_in;
    logic          a_we;
    logic          b_we;
    logic          r_we;
    logic          mac_en;
    logic          mac_clr;
    logic [DW-1:0] mac_res;
    logic          mac_ovf;

    // Write strobes and memory addresses derived from the current state and
    // the (i,j,k) loop indices; k is innermost so each result closes at k=N-1.
    always_comb begin
        beat_in  = in_valid & in_ready;
        a_we     = beat_in && (state == LOAD_A);
        b_we     = beat_in && (state == LOAD_B);
        mac_en   = (state == CALC);
        mac_clr  = (k_idx == '0);
        r_we     = mac_en && (k_idx == LAST_IDX);
        a_addr   = CW'(i_idx * N + k_idx);
        b_addr   = CW'(k_idx * N + j_idx);
        r_addr   = CW'(i_idx * N + j_idx);
        next_cnt = cnt + CW'(1);
    end

    // Operand and result storage; contents need no reset because every run
    // rewrites all entries before they are read.
    always_ff @(posedge clk) begin
        if (a_we) begin
            a_mem[cnt] <= data_in;
        end
        if (b_we) begin
            b_mem[cnt] <= data_in;
        end
        if (r_we) begin
            r_mem[r_addr] <= mac_res;
            r_ovf[r_addr] <= mac_ovf;
        end
    end

    matmul_mac #(
        .DW     (DW),
        .SIGNED (SIGNED),
        .AW     (AW)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .en     (mac_en),
        .clr    (mac_clr),
        .sat_en (sat_reg),
        .a      (a_mem[a_addr]),
        .b      (b_mem[b_addr]),
        .res    (mac_res),
        .ovf    (mac_ovf)
    );

    // Controller: sequences load, calculate and output phases and registers
    // every handshake/status output so they change only on clock edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            i_idx     <= '0;
            j_idx     <= '0;
            k_idx     <= '0;
            sat_reg   <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            dataout   <= '0;
            out_ovf   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (st) begin
                        state    <= LOAD_A;
                        sat_reg  <= sat_en;
                        cnt      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD_A: begin
                    if (beat_in) begin
                        if (cnt == LAST_ELEM) begin
                            cnt   <= '0;
                            state <= LOAD_B;
                        end else begin
                            cnt <= next_cnt;
                        end
                    end
                end
                LOAD_B: begin
                    if (beat_in) begin
                        if (cnt == LAST_ELEM) begin
                            cnt      <= '0;
                            state    <= CALC;
                            in_ready <= 1'b0;
                            i_idx    <= '0;
                            j_idx    <= '0;
                            k_idx    <= '0;
                        end else begin
                            cnt <= next_cnt;
                        end
                    end
                end
                CALC: begin
                    if (k_idx == LAST_IDX) begin
                        k_idx <= '0;
                        if (j_idx == LAST_IDX) begin
                            j_idx <= '0;
                            if (i_idx == LAST_IDX) begin
                                i_idx     <= '0;
                                state     <= OUT;
                                out_valid <= 1'b1;
                                dataout   <= r_mem[cnt];
                                out_ovf   <= r_ovf[cnt];
                            end else begin
                                i_idx <= i_idx + KW'(1);
                            end
                        end else begin
                            j_idx <= j_idx + KW'(1);
                        end
                    end else begin
                        k_idx <= k_idx + KW'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        if (cnt == LAST_ELEM) begin
                            state     <= IDLE;
                            cnt       <= '0;
                            out_valid <= 1'b0;
                            dataout   <= '0;
                            out_ovf   <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            cnt     <= next_cnt;
                            dataout <= r_mem[next_cnt];
                            out_ovf <= r_ovf[next_cnt];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_param.sv
// Self-checking bench for matmul_param: a 3x3 signed instance and a 2x2
// unsigned instance share the stream inputs but have separate start lines.
module tb_matmul_param;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          st_m;
    logic          st_u;
    logic          sat_en;
    logic          in_valid;
    logic          out_ready;
    logic [DW-1:0] data_in;

    logic          m_in_ready, m_out_valid, m_out_ovf, m_busy, m_done;
    logic [DW-1:0] m_dataout;
    logic          u_in_ready, u_out_valid, u_out_ovf, u_busy, u_done;
    logic [DW-1:0] u_dataout;

    int            a_vals [64];
    int            b_vals [64];
    logic [DW-1:0] exp_data [64];
    logic          exp_ovf [64];

    int tests_run;
    int tests_failed;

    matmul_param #(.N(3), .DW(DW), .SIGNED(1)) dut_m (
        .clk(clk), .rst(rst), .st(st_m), .sat_en(sat_en),
        .in_valid(in_valid), .in_ready(m_in_ready), .data_in(data_in),
        .out_valid(m_out_valid), .out_ready(out_ready), .dataout(m_dataout),
        .out_ovf(m_out_ovf), .busy(m_busy), .done(m_done)
    );

    matmul_param #(.N(2), .DW(DW), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .st(st_u), .sat_en(sat_en),
        .in_valid(in_valid), .in_ready(u_in_ready), .data_in(data_in),
        .out_valid(u_out_valid), .out_ready(out_ready), .dataout(u_dataout),
        .out_ovf(u_out_ovf), .busy(u_busy), .done(u_done)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the DUT deadlocks beyond every bounded wait.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic curInReady(input bit sel);
        return sel ? u_in_ready : m_in_ready;
    endfunction
    function automatic logic curOutValid(input bit sel);
        return sel ? u_out_valid : m_out_valid;
    endfunction
    function automatic logic [DW-1:0] curData(input bit sel);
        return sel ? u_dataout : m_dataout;
    endfunction
    function automatic logic curOvf(input bit sel);
        return sel ? u_out_ovf : m_out_ovf;
    endfunction
    function automatic logic curBusy(input bit sel);
        return sel ? u_busy : m_busy;
    endfunction
    function automatic logic curDone(input bit sel);
        return sel ? u_done : m_done;
    endfunction

    task automatic setSt(input bit sel, input logic v);
        if (sel) st_u = v;
        else     st_m = v;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic fillIdentity(input int n);
        for (int i = 0; i < n * n; i++) begin
            a_vals[i] = (i / n == i % n) ? 1 : 0;
            b_vals[i] = i + 1;
        end
    endtask

    task automatic fillConst(input int n, input int av, input int bv);
        for (int i = 0; i < n * n; i++) begin
            a_vals[i] = av;
            b_vals[i] = bv;
        end
    endtask

    task automatic fillRandom(input int n, input bit sgn);
        for (int i = 0; i < n * n; i++) begin
            a_vals[i] = int'($urandom_range(0, 255)) - (sgn ? 128 : 0);
            b_vals[i] = int'($urandom_range(0, 255)) - (sgn ? 128 : 0);
        end
    endtask

    // Reference: exact integer matrix product, then clamp or wrap into DW bits;
    // overflow means the exact value lies outside the representable range.
    task automatic computeExpected(input int n, input bit sgn, input bit sat);
        longint s;
        longint v;
        longint lo;
        longint hi;
        lo = sgn ? -(2 ** (DW - 1)) : 0;
        hi = sgn ? (2 ** (DW - 1)) - 1 : (2 ** DW) - 1;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int k = 0; k < n; k++) begin
                    s += longint'(a_vals[i*n+k]) * longint'(b_vals[k*n+j]);
                end
                exp_ovf[i*n+j] = (s < lo) || (s > hi);
                if (sat) v = (s < lo) ? lo : ((s > hi) ? hi : s);
                else     v = s;
                exp_data[i*n+j] = v[DW-1:0];
            end
        end
    endtask

    // Start a run and stream A then B, optionally with random valid gaps and a
    // stray start pulse once loading of B is under way.
    task automatic applyStimulus(input bit sel, input int n, input bit sat, input bit gaps, input bit st_in_load_b);
        int            idx;
        int            guard;
        bit            pulsed;
        logic [DW-1:0] elem;
        pulsed = 0;
        sat_en = sat;
        @(negedge clk);
        setSt(sel, 1'b1);
        @(negedge clk);
        setSt(sel, 1'b0);
        sat_en = ~sat;
        checkOutput("start_in_ready", 32'(curInReady(sel)), 32'd1);
        checkOutput("start_busy", 32'(curBusy(sel)), 32'd1);
        idx = 0;
        guard = 0;
        while (idx < 2 * n * n && guard < 4000) begin
            setSt(sel, 1'b0);
            if (st_in_load_b && !pulsed && idx == n * n + 1) begin
                setSt(sel, 1'b1);
                pulsed = 1;
            end
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                data_in  = DW'($urandom);
            end else begin
                if (idx < n * n) elem = a_vals[idx][DW-1:0];
                else             elem = b_vals[idx-n*n][DW-1:0];
                in_valid = 1'b1;
                data_in  = elem;
                if (curInReady(sel)) idx++;
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        setSt(sel, 1'b0);
        checkOutput("load_beats", 32'(idx), 32'(2 * n * n));
    endtask

    // Wait out the calculation, then drain and check every result, optionally
    // stalling mid-stream and pulsing start while results are being returned.
    task automatic collectResults(input bit sel, input int n, input bit stall, input bit st_in_out);
        int            idx;
        int            waited;
        int            guard;
        bit            stalled;
        bit            pulsed;
        logic [DW-1:0] held;
        stalled = 0;
        pulsed  = 0;
        waited  = 0;
        in_valid = 1'b1;
        while (!curOutValid(sel) && waited < 1000) begin
            data_in = DW'($urandom);
            @(negedge clk);
            waited++;
        end
        in_valid = 1'b0;
        checkOutput("calc_latency", 32'(waited), 32'(n * n * n));
        idx = 0;
        guard = 0;
        while (idx < n * n && guard < 1000) begin
            setSt(sel, 1'b0);
            if (st_in_out && !pulsed && idx == 2) begin
                setSt(sel, 1'b1);
                pulsed = 1;
            end
            if (stall && !stalled && idx == n * n / 2) begin
                out_ready = 1'b0;
                held = curData(sel);
                stalled = 1;
                repeat (5) begin
                    @(negedge clk);
                    setSt(sel, 1'b0);
                    guard++;
                    checkOutput("stall_hold_data", 32'(curData(sel)), 32'(held));
                end
                checkOutput("stall_hold_valid", 32'(curOutValid(sel)), 32'd1);
            end
            out_ready = 1'b1;
            if (curOutValid(sel)) begin
                checkOutput($sformatf("result_data[%0d]", idx), 32'(curData(sel)), 32'(exp_data[idx]));
                checkOutput($sformatf("result_ovf[%0d]", idx), 32'(curOvf(sel)), 32'(exp_ovf[idx]));
                checkOutput("done_early", 32'(curDone(sel)), 32'd0);
                idx++;
            end
            @(negedge clk);
            guard++;
        end
        setSt(sel, 1'b0);
        checkOutput("result_count", 32'(idx), 32'(n * n));
        checkOutput("done_pulse", 32'(curDone(sel)), 32'd1);
        checkOutput("idle_busy", 32'(curBusy(sel)), 32'd0);
        checkOutput("idle_out_valid", 32'(curOutValid(sel)), 32'd0);
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("done_single", 32'(curDone(sel)), 32'd0);
    endtask

    // Directed sequence of runs covering the main function and boundaries.
    initial begin
        bit rsat;
        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b1;
        st_m      = 1'b0;
        st_u      = 1'b0;
        sat_en    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs_m", 32'({m_in_ready, m_out_valid, m_dataout, m_out_ovf, m_busy, m_done}), 32'd0);
        checkOutput("reset_outputs_u", 32'({u_in_ready, u_out_valid, u_dataout, u_out_ovf, u_busy, u_done}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        fillIdentity(3);
        computeExpected(3, 1, 1);
        applyStimulus(0, 3, 1, 0, 0);
        collectResults(0, 3, 0, 0);

        fillConst(3, 2, 100);
        computeExpected(3, 1, 1);
        applyStimulus(0, 3, 1, 0, 0);
        collectResults(0, 3, 0, 0);
        computeExpected(3, 1, 0);
        applyStimulus(0, 3, 0, 0, 0);
        collectResults(0, 3, 0, 0);

        fillConst(3, -3, 4);
        computeExpected(3, 1, 1);
        applyStimulus(0, 3, 1, 0, 0);
        collectResults(0, 3, 0, 0);

        fillRandom(3, 1);
        rsat = 1'($urandom);
        computeExpected(3, 1, rsat);
        applyStimulus(0, 3, rsat, 1, 1);
        collectResults(0, 3, 1, 1);
        applyStimulus(0, 3, rsat, 0, 0);
        collectResults(0, 3, 0, 0);

        fillIdentity(3);
        applyStimulus(0, 3, 1, 0, 0);
        repeat (10) @(negedge clk);
        checkOutput("calc_busy", 32'(m_busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("abort_outputs", 32'({m_in_ready, m_out_valid, m_dataout, m_out_ovf, m_busy, m_done}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        computeExpected(3, 1, 1);
        applyStimulus(0, 3, 1, 0, 0);
        collectResults(0, 3, 0, 0);

        for (int r = 0; r < 2; r++) begin
            fillRandom(3, 1);
            rsat = 1'($urandom);
            computeExpected(3, 1, rsat);
            applyStimulus(0, 3, rsat, 1, 0);
            collectResults(0, 3, 1, 0);
        end

        a_vals[0] = 1; a_vals[1] = 2; a_vals[2] = 3; a_vals[3] = 4;
        b_vals[0] = 5; b_vals[1] = 6; b_vals[2] = 7; b_vals[3] = 8;
        computeExpected(2, 0, 1);
        applyStimulus(1, 2, 1, 0, 0);
        collectResults(1, 2, 0, 0);

        fillConst(2, 255, 255);
        computeExpected(2, 0, 1);
        applyStimulus(1, 2, 1, 0, 0);
        collectResults(1, 2, 0, 0);
        computeExpected(2, 0, 0);
        applyStimulus(1, 2, 0, 0, 0);
        collectResults(1, 2, 0, 0);

        fillRandom(2, 0);
        rsat = 1'($urandom);
        computeExpected(2, 0, rsat);
        applyStimulus(1, 2, rsat, 1, 1);
        collectResults(1, 2, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/matmul_param.md
Name: matmul_param

Overview:
Parametrised successor to the fixed 3x3 serial matrix multiplier. Computes C = A x B for NxN matrices of DW-bit elements. Elements are loaded over a valid/ready stream and results are returned over a valid/ready stream. Adds signed/unsigned arithmetic, selectable saturate/truncate output, per-result overflow flag, and backpressure. It sits in the same place as the existing top level: one controller FSM plus a datapath with operand and result memories.

Parameters:
N, 3, matrix dimension (2..8)
DW, 8, element and output data width
SIGNED, 1, 1 = two's-complement operands and results; 0 = unsigned
AW, 2*DW+$clog2(N), accumulator width; must be at least 2*DW+$clog2(N)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
st  in  1  start request; sampled only in IDLE
sat_en  in  1  1 = saturate results to DW bits, 0 = truncate to low DW bits; latched on st
in_valid  in  1  input element valid
in_ready  out  1  block accepts an input element
data_in  in  DW  input element: A row-major, then B row-major
out_valid  out  1  result element valid
out_ready  in  1  downstream accepts a result element
dataout  out  DW  result element, C row-major
out_ovf  out  1  current dataout was clamped (sat_en=1) or lost upper bits (sat_en=0)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the last result has been accepted

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE. All counters cleared. Outputs in_ready, out_valid, dataout, out_ovf, busy and done are 0. Memory contents are don't-care.
- States and transitions:
  - IDLE -> LOAD_A when st=1. Latch sat_en. busy rises the next cycle.
  - LOAD_A: in_ready=1. Store one element per in_valid&in_ready beat. After the N*N-th beat -> LOAD_B.
  - LOAD_B: same as LOAD_A for B. After the N*N-th beat -> CALC.
  - CALC: in_ready=0. One MAC per cycle over indices (i,j,k), k innermost.
    - Accumulator is cleared at k=0 (first product loaded, not added).
    - At k=N-1 the final sum is written to result memory [i*N+j] with its ovf bit.
    - Takes exactly N^3 cycles, then -> OUT.
  - OUT: out_valid=1. dataout/out_ovf present result [idx]. idx advances only on out_valid&out_ready; dataout is held stable while stalled. After the N*N-th accepted beat -> IDLE with done=1 for exactly one cycle (that first IDLE cycle).
- Arithmetic:
  - Products are 2*DW bits, sign- or zero-extended to AW per SIGNED. Sums never overflow AW.
  - Saturate, SIGNED=1: clamp to [-2^(DW-1), 2^(DW-1)-1]. SIGNED=0: clamp to [0, 2^DW-1]. out_ovf=1 iff clamped.
  - Truncate: dataout = acc[DW-1:0]. out_ovf=1 iff the discarded upper bits are not a sign/zero extension of the kept bits.
- Boundary conditions:
  - st while busy is ignored (no restart, no error).
  - in_valid outside LOAD_A/LOAD_B is ignored.
  - in_valid gaps stall loading with no timeout.
  - out_ready held low stalls OUT indefinitely.
  - rst mid-operation aborts immediately. The next st starts a fresh load; no partial data is reused.
  - st asserted in the same cycle done pulses is accepted (IDLE).
- Latency at N=3 with no stalls: st -> first in_ready = 1 cycle; load 18 cycles; CALC 27 cycles; first out_valid the cycle after CALC ends.

Decomposition:
- Package matmul_pkg: state enum (IDLE, LOAD_A, LOAD_B, CALC, OUT), ceil-log2 helper, and saturation/overflow function taking DW, SIGNED and AW.
- One sub-module, matmul_mac: registered multiply-accumulate with clear, sign mode, and saturate/truncate output stage.
- Controller FSM and counters stay in matmul_param; operand and result memories are inferred arrays there.

Test Plan:
- N=3, SIGNED=1, sat_en=1: A = identity, B = 1..9 -> dataout 1..9 in order, out_ovf all 0, single done pulse after the 9th accept.
- A all 2, B all 100, sat_en=1 -> every result 127 with out_ovf=1. Same data with sat_en=0 -> 600 mod 256 = 88, out_ovf=1.
- SIGNED=1: A all -3, B all 4 -> every result -36 (0xDC), out_ovf=0. SIGNED=0 with A all 255, B all 255, sat_en=1 -> 255, out_ovf=1.
- Random in_valid gaps and out_ready held low for 5 cycles mid-stream -> results identical to the no-stall run, dataout stable while stalled, no beat lost or duplicated.
- rst asserted during CALC -> all outputs 0 immediately. A subsequent full run with A = identity, B = 1..9 gives 1..9.
- st pulsed during LOAD_B and during OUT -> ignored, results unaffected. N=2 build: A=[1 2;3 4], B=[5 6;7 8] -> 19, 22, 43, 50.
